// File: rtl/pipe_issue_ctrl.sv
// pipe_issue_ctrl
//   Issue controller between decode and execute of the 4-stage 8-bit pipeline.
//   A busy-bit scoreboard holds back any decoded instruction whose sources
//   or destination are still waiting for writeback. While the instruction
//   is held, IF/ID stalls and a NOP bubble is sent into ID/EX.
//   The block also contains:
//     - a debug run/drain/halt/single-step sequencer,
//     - saturating hazard-stall and wrapping issue counters,
//     - a watchdog that breaks a stall which never resolves.
//
// Ports
//   clk, reset                    clock, asynchronous active-high reset
//   dec_valid/opcode/rd/rs1/rs2   decoded instruction sitting in IF/ID
//   wb_valid, wb_dest             register commit from writeback
//   dbg_halt/step/resume          debug request pulses
//   issue, stall, bubble          combinational pipeline control
//   busy                          registered scoreboard, one bit per register
//   halted                        sequencer is parked in HALTED
//   stall_cnt, issue_cnt          performance counters
//   err_stuck                     sticky watchdog flag
module pipe_issue_ctrl #(
  parameter int NREGS     = 8,
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_valid,
  input  logic [3:0]       dec_opcode,
  input  logic [2:0]       dec_rd,
  input  logic [2:0]       dec_rs1,
  input  logic [2:0]       dec_rs2,
  input  logic             wb_valid,
  input  logic [2:0]       wb_dest,
  input  logic             dbg_halt,
  input  logic             dbg_step,
  input  logic             dbg_resume,
  output logic             issue,
  output logic             stall,
  output logic             bubble,
  output logic [NREGS-1:0] busy,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] issue_cnt,
  output logic             err_stuck
);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED, S_STEP} state_t;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_LOAD = 4'd2;

  state_t           state_q, state_d;
  logic [NREGS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0] run_len_q, run_len_d;
  logic             err_stuck_q, err_stuck_d;

  logic reads_rs1, reads_rs2, writes_rd;
  logic hazard, can_issue, hz_stall;

  // Operand usage by opcode; anything that is not ADD/SUB/LOAD is a NOP.
  assign reads_rs1 = (dec_opcode == OP_ADD) || (dec_opcode == OP_SUB) || (dec_opcode == OP_LOAD);
  assign reads_rs2 = (dec_opcode == OP_ADD) || (dec_opcode == OP_SUB);
  assign writes_rd = reads_rs1;

  // Registered busy only: a same-cycle writeback releases a waiting reader
  // one cycle later, because there is no bypass path.
  assign hazard = dec_valid && ((reads_rs1 && busy_q[dec_rs1]) ||
                                (reads_rs2 && busy_q[dec_rs2]) ||
                                (writes_rd && busy_q[dec_rd]));

  // STEP leaves for DRAIN on its first issue, so while in STEP the step
  // has not yet issued.
  assign can_issue = (state_q == S_RUN) || (state_q == S_STEP);

  assign issue    = dec_valid && !hazard && can_issue;
  assign stall    = dec_valid && !issue;
  assign bubble   = !issue;
  assign hz_stall = stall && hazard;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    busy_d      = busy_q;
    stall_cnt_d = stall_cnt_q;
    issue_cnt_d = issue_cnt_q;
    err_stuck_d = err_stuck_q;
    state_d     = state_q;

    // The clear is applied first, so a set on the same register wins.
    if (wb_valid)             busy_d[wb_dest] = 1'b0;
    if (issue && writes_rd)   busy_d[dec_rd]  = 1'b1;

    if (issue) issue_cnt_d = issue_cnt_q + 1'b1;
    if (hz_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;

    // Watchdog: a hazard stall that lasts too long is treated as a lost
    // writeback. The scoreboard is flushed so the held instruction can proceed.
    run_len_d = hz_stall ? run_len_q + 1'b1 : '0;
    if (run_len_d == CNT_W'(MAX_STALL)) begin
      err_stuck_d = 1'b1;
      busy_d      = '0;
      run_len_d   = '0;
    end

    unique case (state_q)
      S_RUN:    if (dbg_halt) state_d = S_DRAIN;
      S_DRAIN: begin
        if (dbg_resume)        state_d = S_RUN;
        else if (busy_q == '0) state_d = S_HALTED;
      end
      S_HALTED: begin
        if (dbg_resume)    state_d = S_RUN;
        else if (dbg_step) state_d = S_STEP;
      end
      S_STEP: begin
        if (dbg_resume) state_d = S_RUN;
        else if (issue) state_d = S_DRAIN;
      end
      default: state_d = S_RUN;
    endcase
  end

  // NOTE: the scoreboard is a small flop array, not a RAM, so it resets with the rest of the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_RUN;
      busy_q      <= '0;
      stall_cnt_q <= '0;
      issue_cnt_q <= '0;
      run_len_q   <= '0;
      err_stuck_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
      state_q     <= state_d;
      busy_q      <= busy_d;
      stall_cnt_q <= stall_cnt_d;
      issue_cnt_q <= issue_cnt_d;
      run_len_q   <= run_len_d;
      err_stuck_q <= err_stuck_d;
    end
  end

  assign busy      = busy_q;
  assign halted    = (state_q == S_HALTED);
  assign stall_cnt = stall_cnt_q;
  assign issue_cnt = issue_cnt_q;
  assign err_stuck = err_stuck_q;

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// tb_pipe_issue_ctrl
//   Directed self-checking bench for pipe_issue_ctrl with MAX_STALL=4.
//   Inputs change 1 time unit after the rising edge. Outputs are sampled
//   1 time unit later, well away from the next rising edge.
module tb_pipe_issue_ctrl;

  localparam logic [3:0] ADD  = 4'd0;
  localparam logic [3:0] SUB  = 4'd1;
  localparam logic [3:0] LOAD = 4'd2;
  localparam logic [3:0] NOP  = 4'd15;

  logic        clk, reset;
  logic        dec_valid;
  logic [3:0]  dec_opcode;
  logic [2:0]  dec_rd, dec_rs1, dec_rs2;
  logic        wb_valid;
  logic [2:0]  wb_dest;
  logic        dbg_halt, dbg_step, dbg_resume;
  logic        issue, stall, bubble, halted, err_stuck;
  logic [7:0]  busy;
  logic [15:0] stall_cnt, issue_cnt;

  int checks = 0;
  int errors = 0;

  pipe_issue_ctrl #(.NREGS(8), .CNT_W(16), .MAX_STALL(4)) dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid), .dec_opcode(dec_opcode), .dec_rd(dec_rd),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .wb_valid(wb_valid), .wb_dest(wb_dest),
    .dbg_halt(dbg_halt), .dbg_step(dbg_step), .dbg_resume(dbg_resume),
    .issue(issue), .stall(stall), .bubble(bubble), .busy(busy),
    .halted(halted), .stall_cnt(stall_cnt), .issue_cnt(issue_cnt),
    .err_stuck(err_stuck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dec(input logic v, input logic [3:0] op, input logic [2:0] rd,
                     input logic [2:0] rs1, input logic [2:0] rs2);
    dec_valid  = v;
    dec_opcode = op;
    dec_rd     = rd;
    dec_rs1    = rs1;
    dec_rs2    = rs2;
  endtask

  task automatic wb(input logic v, input logic [2:0] d);
    wb_valid = v;
    wb_dest  = d;
  endtask

  // Checks issue/stall/bubble together after inputs settle.
  task automatic ctl(input string tag, input logic ei, input logic es, input logic eb);
    #1;
    check({tag, ".issue"},  32'(issue),  32'(ei));
    check({tag, ".stall"},  32'(stall),  32'(es));
    check({tag, ".bubble"}, 32'(bubble), 32'(eb));
  endtask

  initial begin
    reset = 1'b1;
    dec(1'b0, NOP, 3'd0, 3'd0, 3'd0);
    wb(1'b0, 3'd0);
    dbg_halt = 1'b0; dbg_step = 1'b0; dbg_resume = 1'b0;
    tick(); tick();

    // Reset state
    check("rst.busy", 32'(busy), 32'h00);
    check("rst.halted", 32'(halted), 32'd0);
    check("rst.stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst.issue_cnt", 32'(issue_cnt), 32'd0);
    check("rst.err_stuck", 32'(err_stuck), 32'd0);
    ctl("rst", 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    tick();

    // 1: independent stream
    dec(1'b1, ADD, 3'd1, 3'd2, 3'd3);
    ctl("t1.add", 1'b1, 1'b0, 1'b0);
    tick();
    check("t1.busy_a", 32'(busy), 32'h02);
    dec(1'b1, SUB, 3'd4, 3'd5, 3'd6);
    ctl("t1.sub", 1'b1, 1'b0, 1'b0);
    tick();
    check("t1.busy_b", 32'(busy), 32'h12);
    dec(1'b0, NOP, 3'd0, 3'd0, 3'd0);
    wb(1'b1, 3'd1);
    tick();
    check("t1.busy_c", 32'(busy), 32'h10);
    wb(1'b1, 3'd4);
    tick();
    wb(1'b0, 3'd0);
    check("t1.busy_d", 32'(busy), 32'h00);
    check("t1.stall_cnt", 32'(stall_cnt), 32'd0);
    check("t1.issue_cnt", 32'(issue_cnt), 32'd2);

    // 2: RAW hazard, released the cycle after writeback
    dec(1'b1, ADD, 3'd1, 3'd2, 3'd3);
    tick();
    dec(1'b1, ADD, 3'd5, 3'd1, 3'd2);
    ctl("t2.s1", 1'b0, 1'b1, 1'b1);
    tick();
    ctl("t2.s2", 1'b0, 1'b1, 1'b1);
    tick();
    wb(1'b1, 3'd1);
    ctl("t2.s3_wb", 1'b0, 1'b1, 1'b1);
    tick();
    wb(1'b0, 3'd0);
    check("t2.busy_rel", 32'(busy), 32'h00);
    check("t2.stall_cnt", 32'(stall_cnt), 32'd3);
    ctl("t2.go", 1'b1, 1'b0, 1'b0);
    tick();
    check("t2.busy_r5", 32'(busy), 32'h20);
    check("t2.issue_cnt", 32'(issue_cnt), 32'd4);
    dec(1'b0, NOP, 3'd0, 3'd0, 3'd0);
    wb(1'b1, 3'd5);
    tick();

    // 3: WAW stall, then same-cycle set/clear on R7
    dec(1'b1, ADD, 3'd7, 3'd2, 3'd3);
    wb(1'b0, 3'd0);
    tick();
    check("t3.busy_r7", 32'(busy), 32'h80);
    dec(1'b1, LOAD, 3'd7, 3'd0, 3'd4);   // LOAD R7,4(R0); rs2 is ignored
    ctl("t3.waw", 1'b0, 1'b1, 1'b1);
    tick();
    wb(1'b1, 3'd7);
    ctl("t3.waw_wb", 1'b0, 1'b1, 1'b1);
    tick();
    wb(1'b0, 3'd0);
    ctl("t3.load_go", 1'b1, 1'b0, 1'b0);
    tick();
    check("t3.stall_cnt", 32'(stall_cnt), 32'd5);
    dec(1'b0, NOP, 3'd0, 3'd0, 3'd0);
    wb(1'b1, 3'd7);
    tick();
    check("t3.busy_clr", 32'(busy), 32'h00);
    dec(1'b1, ADD, 3'd7, 3'd1, 3'd2);    // stale wb to R7 while ADD R7 issues
    ctl("t3.setclr", 1'b1, 1'b0, 1'b0);
    tick();
    check("t3.set_wins", 32'(busy), 32'h80);
    check("t3.issue_cnt", 32'(issue_cnt), 32'd7);
    dec(1'b0, NOP, 3'd0, 3'd0, 3'd0);
    tick();
    wb(1'b0, 3'd0);
    check("t3.busy_end", 32'(busy), 32'h00);

    // 4: watchdog trips after 4 hazard-stall cycles
    dec(1'b1, ADD, 3'd1, 3'd2, 3'd3);
    tick();
    dec(1'b1, ADD, 3'd2, 3'd1, 3'd1);
    ctl("t4.stall", 1'b0, 1'b1, 1'b1);
    tick(); tick(); tick();
    check("t4.err_pre", 32'(err_stuck), 32'd0);
    check("t4.busy_pre", 32'(busy), 32'h02);
    tick();
    check("t4.err_set", 32'(err_stuck), 32'd1);
    check("t4.busy_flush", 32'(busy), 32'h00);
    check("t4.stall_cnt", 32'(stall_cnt), 32'd9);
    ctl("t4.go", 1'b1, 1'b0, 1'b0);
    tick();
    check("t4.busy_r2", 32'(busy), 32'h04);
    check("t4.issue_cnt", 32'(issue_cnt), 32'd9);
    dec(1'b0, NOP, 3'd0, 3'd0, 3'd0);
    wb(1'b1, 3'd2);
    tick();
    wb(1'b0, 3'd0);
    check("t4.err_sticky", 32'(err_stuck), 32'd1);

    // 5: halt, drain, single step, step+resume
    dec(1'b1, ADD, 3'd1, 3'd2, 3'd3);
    tick();
    dec(1'b0, NOP, 3'd0, 3'd0, 3'd0);
    dbg_halt = 1'b1;
    tick();
    dbg_halt = 1'b0;
    check("t5.busy_drain", 32'(busy), 32'h02);
    dec(1'b1, ADD, 3'd3, 3'd4, 3'd5);
    ctl("t5.drain", 1'b0, 1'b1, 1'b1);
    check("t5.halted_d0", 32'(halted), 32'd0);
    tick();
    wb(1'b1, 3'd1);
    ctl("t5.drain_wb", 1'b0, 1'b1, 1'b1);
    tick();
    wb(1'b0, 3'd0);
    check("t5.halted_d1", 32'(halted), 32'd0);
    tick();
    check("t5.halted", 32'(halted), 32'd1);
    check("t5.issue_cnt_h", 32'(issue_cnt), 32'd10);
    check("t5.stall_cnt_h", 32'(stall_cnt), 32'd9);
    ctl("t5.halted", 1'b0, 1'b1, 1'b1);
    dbg_step = 1'b1;
    tick();
    dbg_step = 1'b0;
    check("t5.step_halted", 32'(halted), 32'd0);
    ctl("t5.step", 1'b1, 1'b0, 1'b0);
    tick();
    check("t5.step_cnt", 32'(issue_cnt), 32'd11);
    check("t5.step_busy", 32'(busy), 32'h08);
    dec(1'b1, ADD, 3'd6, 3'd4, 3'd5);
    ctl("t5.one_only", 1'b0, 1'b1, 1'b1);
    wb(1'b1, 3'd3);
    tick();
    wb(1'b0, 3'd0);
    tick();
    check("t5.rehalted", 32'(halted), 32'd1);
    check("t5.issue_cnt_h2", 32'(issue_cnt), 32'd11);
    dbg_step = 1'b1;
    dbg_resume = 1'b1;
    tick();
    dbg_step = 1'b0;
    dbg_resume = 1'b0;
    check("t5.resume_halted", 32'(halted), 32'd0);
    ctl("t5.resume", 1'b1, 1'b0, 1'b0);
    tick();
    check("t5.resume_cnt", 32'(issue_cnt), 32'd12);
    dec(1'b0, NOP, 3'd0, 3'd0, 3'd0);
    wb(1'b1, 3'd6);
    tick();
    wb(1'b0, 3'd0);

    // 6: async reset in the middle of a drain
    dec(1'b1, ADD, 3'd0, 3'd1, 3'd2);
    tick();
    dec(1'b1, ADD, 3'd7, 3'd1, 3'd2);
    tick();
    dec(1'b0, NOP, 3'd0, 3'd0, 3'd0);
    dbg_halt = 1'b1;
    tick();
    dbg_halt = 1'b0;
    dec(1'b1, ADD, 3'd3, 3'd4, 3'd5);
    ctl("t6.drain", 1'b0, 1'b1, 1'b1);
    check("t6.busy_pre", 32'(busy), 32'h81);
    check("t6.issue_cnt_pre", 32'(issue_cnt), 32'd14);
    tick();
    check("t6.halted_pre", 32'(halted), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check("t6.busy_rst", 32'(busy), 32'h00);
    check("t6.halted_rst", 32'(halted), 32'd0);
    check("t6.stall_cnt_rst", 32'(stall_cnt), 32'd0);
    check("t6.issue_cnt_rst", 32'(issue_cnt), 32'd0);
    check("t6.err_rst", 32'(err_stuck), 32'd0);
    tick();
    reset = 1'b0;
    dec(1'b1, ADD, 3'd2, 3'd1, 3'd3);
    wb(1'b1, 3'd7);                      // stale writeback after reset
    ctl("t6.run", 1'b1, 1'b0, 1'b0);
    tick();
    wb(1'b0, 3'd0);
    dec(1'b0, NOP, 3'd0, 3'd0, 3'd0);
    check("t6.busy_post", 32'(busy), 32'h04);
    check("t6.issue_cnt_post", 32'(issue_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
